// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: shared bus sizes, alu/div op indices, ID->EX payload layout and divider states
package ex_unit_pkg;
    localparam int ID_TO_EX_BUS_SIZE = 155;
    localparam int EX_TO_ME_BUS_SIZE = 76;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;
    localparam int DIV_W    = 0;
    localparam int MOD_W    = 1;
    localparam int DIV_WU   = 2;
    localparam int MOD_WU   = 3;
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [3:0]  div_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        mem_we;
        logic        mem_b;
        logic        mem_h;
        logic        mem_signed;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } id_ex_t;
    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] v);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/ex_unit_if.sv
// ex_unit_if: ID->EX input bus, EX->ME output bus, forwarding info and data-SRAM request.
//   slave  : seen by ex_unit (receives ID bus and ME_Allow_in, drives everything else)
//   master : seen by the surrounding pipeline / bench
interface ex_unit_if;
    import ex_unit_pkg::*;
    logic                         ID_to_EX_Valid;
    logic [ID_TO_EX_BUS_SIZE-1:0] ID_to_EX_Bus;
    logic                         ME_Allow_in;
    logic                         EX_Allow_in;
    logic                         EX_to_ME_Valid;
    logic [EX_TO_ME_BUS_SIZE-1:0] EX_to_ME_Bus;
    logic [4:0]                   EX_dest;
    logic [31:0]                  EX_Forward_Res;
    logic                         EX_Fwd_Block;
    logic                         data_sram_en;
    logic [3:0]                   data_sram_we;
    logic [31:0]                  data_sram_addr;
    logic [31:0]                  data_sram_wdata;
    modport slave (
        input  ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
        output EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, EX_dest, EX_Forward_Res,
               EX_Fwd_Block, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
    modport master (
        output ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
        input  EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, EX_dest, EX_Forward_Res,
               EX_Fwd_Block, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_divider.sv
// ex_divider: 32-cycle restoring divider with IDLE/BUSY/DONE control.
//   clk, reset (async, active-high); start: request (taken in IDLE); signed_op: signed div/mod;
//   dividend, divisor: operands; ack: result consumed (DONE -> IDLE);
//   busy, done: state flags; quotient, remainder: signed-corrected results, held in DONE.
module ex_divider
    import ex_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    div_state_e  state, next;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, dsr;
    logic        q_neg, r_neg, dz;
    logic [32:0] diff;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= DIV_IDLE;
        else       state <= next;
    always_comb begin
        next = state;
        case (state)
            DIV_IDLE: next = start ? DIV_BUSY : DIV_IDLE;
            DIV_BUSY: next = (cnt == 5'd0) ? DIV_DONE : DIV_BUSY;
            DIV_DONE: next = ack ? DIV_IDLE : DIV_DONE;
            default:  next = DIV_IDLE;
        endcase
    end
    // quo doubles as the dividend shift register: its MSB shifts into rem each step
    assign diff = {rem, quo[31]} - {1'b0, dsr};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz    <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= 5'd31;
            rem   <= '0;
            quo   <= apply_sign(signed_op && dividend[31], dividend);
            dsr   <= apply_sign(signed_op && divisor[31], divisor);
            q_neg <= signed_op && (dividend[31] ^ divisor[31]);
            r_neg <= signed_op && dividend[31];
            dz    <= divisor == 32'd0;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt - 5'd1;
            rem <= diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
        end
    assign busy      = state == DIV_BUSY;
    assign done      = state == DIV_DONE;
    // divide-by-zero yields all-ones quotient regardless of sign; remainder naturally equals src1
    assign quotient  = dz ? 32'hFFFF_FFFF : apply_sign(q_neg, quo);
    assign remainder = apply_sign(r_neg, rem);
endmodule

// File: rtl/ex_unit.sv
// ex_unit: LoongArch32 execute stage - ALU, optional iterative divider, data-SRAM request, EX->ME bus.
//   clk, reset (async, active-high)
//   bus (ex_unit_if.slave): ID_to_EX_Valid/Bus in, ME_Allow_in in; EX_Allow_in, EX_to_ME_Valid/Bus,
//   EX_dest, EX_Forward_Res, EX_Fwd_Block, data_sram_en/we/addr/wdata out.
//   Define EX_DIVIDER_EN to build the divider; otherwise div ops complete in one cycle with result 0.
module ex_unit
    import ex_unit_pkg::*;
(
    input logic     clk,
    input logic     reset,
    ex_unit_if.slave bus
);
    id_ex_t      id_in, ex;
    logic        ex_valid, ready_go, allow_in, fire, sub_word;
    logic [31:0] sum, alu_res, div_res, result;
    logic [4:0]  sh;
    logic [1:0]  off;
    logic [4:0]  dest_flag;
    assign id_in    = bus.ID_to_EX_Bus;
    assign allow_in = !ex_valid || (ready_go && bus.ME_Allow_in);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ex_valid <= 1'b0;
            ex       <= '0;
        end else begin
            if (allow_in) ex_valid <= bus.ID_to_EX_Valid;
            if (allow_in && bus.ID_to_EX_Valid) ex <= id_in;
        end
    assign sum = ex.src1 + ex.src2;
    assign sh  = ex.src2[4:0];
    // one-hot select: all-zero alu_op yields 0
    always_comb begin
        alu_res = '0;
        alu_res |= {32{ex.alu_op[ALU_ADD]}}  & sum;
        alu_res |= {32{ex.alu_op[ALU_SUB]}}  & (ex.src1 - ex.src2);
        alu_res |= {32{ex.alu_op[ALU_SLT]}}  & {31'd0, $signed(ex.src1) < $signed(ex.src2)};
        alu_res |= {32{ex.alu_op[ALU_SLTU]}} & {31'd0, ex.src1 < ex.src2};
        alu_res |= {32{ex.alu_op[ALU_AND]}}  & (ex.src1 & ex.src2);
        alu_res |= {32{ex.alu_op[ALU_NOR]}}  & ~(ex.src1 | ex.src2);
        alu_res |= {32{ex.alu_op[ALU_OR]}}   & (ex.src1 | ex.src2);
        alu_res |= {32{ex.alu_op[ALU_XOR]}}  & (ex.src1 ^ ex.src2);
        alu_res |= {32{ex.alu_op[ALU_SLL]}}  & (ex.src1 << sh);
        alu_res |= {32{ex.alu_op[ALU_SRL]}}  & (ex.src1 >> sh);
        alu_res |= {32{ex.alu_op[ALU_SRA]}}  & 32'($signed(ex.src1) >>> sh);
        alu_res |= {32{ex.alu_op[ALU_LUI]}}  & ex.src2;
    end
`ifdef EX_DIVIDER_EN
    logic        div_busy, div_done;
    logic [31:0] quo, rem;
    ex_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (ex_valid && |ex.div_op && !div_busy && !div_done),
        .signed_op(ex.div_op[DIV_W] | ex.div_op[MOD_W]),
        .dividend (ex.src1),
        .divisor  (ex.src2),
        .ack      (bus.EX_to_ME_Valid && bus.ME_Allow_in),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo),
        .remainder(rem)
    );
    assign ready_go = ~|ex.div_op || div_done;
    assign div_res  = (ex.div_op[DIV_W] | ex.div_op[DIV_WU]) ? quo : rem;
`else
    assign ready_go = 1'b1;
    assign div_res  = '0;
`endif
    assign result   = |ex.div_op ? div_res : alu_res;
    assign off      = sum[1:0];
    assign sub_word = ex.mem_b | ex.mem_h;
    // gated by ME_Allow_in so a stalled EX never repeats the request
    assign fire      = ex_valid && ready_go && bus.ME_Allow_in && (ex.res_from_mem || ex.mem_we);
    assign dest_flag = (ex.res_from_mem && sub_word) ? {ex.mem_signed, ex.mem_b, ex.mem_h, off} : 5'd0;
    assign bus.EX_Allow_in     = allow_in;
    assign bus.EX_to_ME_Valid  = ex_valid && ready_go;
    assign bus.EX_to_ME_Bus    = {dest_flag, ex.pc, result, ex.res_from_mem, ex.gr_we, ex.dest};
    assign bus.EX_dest         = ex.dest & {5{ex_valid && ex.gr_we}};
    assign bus.EX_Forward_Res  = result & {32{ex.gr_we}};
    assign bus.EX_Fwd_Block    = ex_valid && (ex.res_from_mem || !ready_go);
    assign bus.data_sram_en    = fire;
    assign bus.data_sram_we    = !(fire && ex.mem_we) ? 4'h0 :
                                 ex.mem_b ? 4'b0001 << off :
                                 ex.mem_h ? 4'b0011 << {off[1], 1'b0} : 4'hF;
    assign bus.data_sram_addr  = sum;
    assign bus.data_sram_wdata = ex.mem_b ? {4{ex.rkd_value[7:0]}} :
                                 ex.mem_h ? {2{ex.rkd_value[15:0]}} : ex.rkd_value;
endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
Execute stage of the 5-stage in-order LoongArch32 pipeline, sitting between the ID stage and the ME stage. It latches decoded operands from ID and computes ALU results. It runs DIV/MOD on an iterative 32-cycle divider, issues the data-SRAM request so read data returns during the ME cycle, and packs the EX_to_ME bus consumed by ME. It also provides forwarding and load-use/busy stall information back to ID.

Parameters:
none. Bus widths come from `ID_to_EX_Bus_Size` (155) and `EX_to_ME_Bus_Size` (76) in my_cpu.vh.

Ports:
clk  in  1  clock, single domain
reset  in  1  asynchronous, active-high reset
ID_to_EX_Valid  in  1  ID has an instruction for EX
ID_to_EX_Bus  in  155  {pc[32], alu_op[12], div_op[4], src1[32], src2[32], rkd_value[32], mem_we, mem_b, mem_h, mem_signed, res_from_mem, gr_we, dest[5]}, MSB first
ME_Allow_in  in  1  ME can accept
EX_Allow_in  out  1  EX can accept
EX_to_ME_Valid  out  1  EX hands instruction to ME
EX_to_ME_Bus  out  76  {dest_flag[5], pc[32], result[32], res_from_mem, gr_we, dest[5]}
EX_dest  out  5  forwarding dest, 0 when invalid or !gr_we
EX_Forward_Res  out  32  current result
EX_Fwd_Block  out  1  EX_Valid && (res_from_mem || !EX_ReadyGO); ID must stall on a dest match
data_sram_en  out  1  SRAM access enable
data_sram_we  out  4  byte write strobes
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  store data

Behaviour:
- Handshake:
  - EX_Allow_in = !EX_Valid || (EX_ReadyGO && ME_Allow_in).
  - EX_to_ME_Valid = EX_Valid && EX_ReadyGO.
  - EX_Valid loads ID_to_EX_Valid whenever EX_Allow_in is high.
  - Payload registers load only when ID_to_EX_Valid && EX_Allow_in.
- Reset: EX_Valid=0, divider state IDLE, payload registers=0. Consequently all SRAM enables/strobes, EX_dest, EX_Fwd_Block and EX_to_ME_Valid are 0.
- Reset asserted mid-divide aborts the operation immediately.
- alu_op is one-hot, index 0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0].
  - lui passes src2.
  - slt/sltu produce 0 or 1 in 32 bits.
  - alu_op all-zero gives result 0.
- div_op is one-hot, index 0..3 = div.w, mod.w, div.wu, mod.wu. Nonzero div_op selects divider output over the ALU result.
- EX_ReadyGO = 1 when div_op==0, else (div state==DONE).
- Divider state machine (sub-module):
  - IDLE -> BUSY on the first cycle EX_Valid holds a div op; operands are latched as magnitudes plus sign.
  - BUSY runs 32 restoring iterations, one per cycle, counter 31..0.
  - BUSY -> DONE when counter reaches 0.
  - DONE -> IDLE when the instruction leaves EX (EX_to_ME_Valid && ME_Allow_in).
  - Minimum EX residency for a div is 34 cycles.
  - DONE holds its result while ME stalls.
- Divider results and signs:
  - Quotient sign = sign(src1) XOR sign(src2).
  - Remainder sign = sign(src1).
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = src1, signed or unsigned.
  - 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
- data_sram_addr = src1 + src2 (the add result); off = addr[1:0].
- Request fire condition: data_sram_en = EX_Valid && EX_ReadyGO && ME_Allow_in && (res_from_mem || mem_we). A stalled EX therefore never issues a duplicate request.
- data_sram_we (0 unless fire && mem_we):
  - byte: 4'b0001 << off.
  - half: 4'b0011 << {off[1],1'b0}.
  - word: 4'hF.
- data_sram_wdata:
  - byte: {4{rkd_value[7:0]}}.
  - half: {2{rkd_value[15:0]}}.
  - word: rkd_value.
- dest_flag = res_from_mem ? {mem_signed, mem_b, mem_h, off} : 5'b0. For a word load it is 5'b00000, off forced 0. Misaligned accesses are not detected.
- EX_dest = dest & {5{EX_Valid && gr_we}}.
- EX_Forward_Res = result & {32{gr_we}}.

Optional Feature:
EX_DIVIDER_EN.
- Defined: divider instantiated, behaviour as above.
- Undefined: no divider is built; div_op is ignored, EX_ReadyGO is tied to 1, and div ops return 0 in a single cycle.

Decomposition:
- my_cpu.vh holds:
  - `ID_to_EX_Bus_Size`, `EX_to_ME_Bus_Size`.
  - alu_op and div_op index macros.
  - dest_flag field positions.
- Sub-module ex_divider (clk, reset, start, signed_op, dividend, divisor, busy, done, ack, quotient, remainder) owns the IDLE/BUSY/DONE state machine.

Test Plan:
- add src1=0x10, src2=0xFFFFFFF0, ME_Allow_in=1 -> EX_to_ME_Valid next cycle, result 0x00000000, single-cycle throughput on back-to-back issue.
- ld.b, src1=0x1000, src2=3, mem_signed=1 -> data_sram_en=1, addr 0x1003, we=0, dest_flag=5'b11011.
- ld.b as above with ME_Allow_in=0 for 3 cycles -> en stays 0 while stalled, pulses exactly once on release.
- st.h, addr 0x2002, rkd=0x1234ABCD -> we=4'b1100, wdata=0xABCDABCD.
- div.w, src1=0xFFFFFFF9 (-7), src2=2 -> EX_Allow_in=0 for 33 cycles, then result 0xFFFFFFFD; mod.w on the same operands gives 0xFFFFFFFF.
- div.wu by 0, with reset asserted mid-BUSY -> EX_Valid=0 immediately. Reissued div.wu by 0 -> 0xFFFFFFFF. With EX_DIVIDER_EN undefined -> result 0 in one cycle.
